lsu_mem_bridge: RTL and testbench
=================================

// Module: lsu_mem_bridge
// PURPOSE
//   Load/store bridge between the core's byte-addressed data requests and the word-addressed Memory block.
//   Converts byte address + funct3 into word index, byte mask and lane-shifted write data.
//   Drives en_mem/mem_rstrb for one cycle, then extracts and sign/zero-extends the read word.
//   Sits directly upstream of Memory, between it and the core's execute stage.
// PARAMETERS
//   SIZE      4096  number of 32-bit words in the downstream Memory; word index >= SIZE is out of range
// PORTS
//   clk        in   1   system clock, all state on posedge
//   rst        in   1   asynchronous, active-high reset
//   req_valid  in   1   core request valid
//   req_ready  out  1   bridge can accept a request (high only in IDLE)
//   req_we     in   1   1=store, 0=load
//   req_funct3 in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load only)
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, right-aligned
//   rsp_valid  out  1   response valid, held until rsp_ready
//   rsp_ready  in   1   core accepts response
//   rsp_rdata  out  32  extended load data; 0 for stores and errors
//   rsp_err    out  1   illegal funct3, out-of-range or (macro) misaligned
//   en_mem     out  1   Memory enable, one cycle per access
//   mem_addr   out  32  word index = {2'b0, req_addr[31:2]}
//   mem_rstrb  out  1   high with en_mem on loads
//   mem_wdata  out  32  store data replicated/shifted to byte lane
//   mem_wmask  out  4   byte write mask; 0 on loads and outside ACCESS
//   mem_rdata  in   32  Memory read word, valid the cycle after en_mem
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1 after reset release; rsp_valid, rsp_err, en_mem, mem_rstrb = 0;
//     mem_wmask, mem_addr, mem_wdata, rsp_rdata = 0.
//   FSM: IDLE -> ACCESS on req_valid&req_ready (request fields registered at that edge).
//     IDLE -> RESP directly if the request is in error: no memory cycle, rsp_err=1.
//     ACCESS: en_mem=1, mem_* driven from registered fields. Store -> RESP. Load -> CAPTURE.
//     CAPTURE: rsp_rdata <= extend(mem_rdata >> 8*addr[1:0]); -> RESP.
//     RESP: rsp_valid=1; on rsp_ready -> IDLE. No new request accepted until then.
//   Latency (accept edge = E0): store rsp_valid from E1; load rsp_valid from E2; error from E0.
//   Store mask: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111. mem_wdata = {4{b}}, {2{h}}, or w.
//   Load extend: B/H sign-extend bit 7/15; BU/HU zero-extend; W passthrough.
//   Errors: funct3 in {011,110,111}; BU/HU with req_we=1; addr[31:2] >= SIZE.
//   Simultaneous rsp_ready and req_valid in RESP: response retires; request is accepted next cycle in IDLE.
//   Reset mid-operation: abandon the transaction, return to IDLE. A store cut before its ACCESS edge never commits.
//   rsp_ready is ignored outside RESP. req_* is sampled only at the accept edge.
// CONFIGURATION
//   LSU_MISALIGN_TRAP_EN defined: H with a[0]!=0, or W with a[1:0]!=0, is an error (rsp_err, no access).
//   Undefined: misaligned addresses are silently aligned down (H clears a[0], W clears a[1:0]); no error.
// STRUCTURE
//   Package lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state encoding (IDLE/ACCESS/CAPTURE/RESP), 2-bit width.
//   Sub-module lsu_data_align (combinational): store mask/shift and load extract/extend, shared by both paths.
// TESTING
//   SW 0x10, 0xDEADBEEF -> mem_addr=4, wmask=1111, wdata=DEADBEEF, rsp_valid on 2nd cycle after accept, err=0.
//   SB 0x13, 0x000000A5 -> wmask=1000, wdata=A5A5A5A5; then LB 0x13 -> rsp_rdata=FFFFFFA5; LBU -> 000000A5.
//   SH 0x16, 0x8001, then LH 0x16 -> wmask=1100, rsp_rdata=FFFF8001; LHU -> 00008001.
//   LW addr=4*SIZE -> rsp_err=1, en_mem never asserted; funct3=011 -> rsp_err=1.
//   LW 0x11: with macro -> rsp_err=1, no access; without -> reads word 4, err=0.
//   Assert rst during ACCESS of SW -> outputs return to reset values; a later LW of that word returns the old data.
//   Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and request legality check shared by the LSU bridge
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  function automatic logic f3_bad(input logic [2:0] f3, input logic we);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (f3[2] && we);
  endfunction
endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: store byte-mask/lane replication and load extract/extend
//   i_funct3/i_off: access size and byte offset; i_wdata/o_wmask/o_wdata: store path;
//   i_rdata/o_rdata: load path (memory word in, extended value out)
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [1:0]  w_off;
  logic [31:0] w_sh;
  // halfwords and words are aligned down; only matters when misaligned accesses are not trapped
  assign w_off   = i_funct3[1] ? 2'b00 : i_funct3[0] ? {i_off[1], 1'b0} : i_off;
  assign o_wmask = i_funct3[1] ? 4'b1111 : i_funct3[0] ? 4'b0011 << w_off : 4'b0001 << w_off;
  assign o_wdata = i_funct3[1] ? i_wdata : i_funct3[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
  assign w_sh    = i_rdata >> {w_off, 3'b000};
  assign o_rdata = i_funct3[1] ? w_sh :
                   i_funct3[0] ? {{16{~i_funct3[2] & w_sh[15]}}, w_sh[15:0]} :
                                 {{24{~i_funct3[2] & w_sh[7]}}, w_sh[7:0]};
endmodule

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: byte-addressed core load/store to word-addressed Memory bridge
//   req_*: core request (ready only in IDLE); rsp_*: held response; en_mem/mem_*: Memory port.
//   LSU_MISALIGN_TRAP_EN: misaligned H/W become errors instead of being aligned down.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        en_mem,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);
  state_t      r_state;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_we;
  logic        w_idle;
  logic        w_err;
  logic        w_mis;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  assign w_idle    = r_state == IDLE;
  assign req_ready = w_idle;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif
  assign w_err = f3_bad(req_funct3, req_we) || {2'b00, req_addr[31:2]} >= SIZE || w_mis;
  // one aligner: fed by the live request in IDLE (store lanes), by the held request afterwards (load extract)
  assign w_f3  = w_idle ? req_funct3 : r_f3;
  assign w_off = w_idle ? req_addr[1:0] : r_off;
  lsu_data_align u_align (
    .i_funct3 (w_f3),
    .i_off    (w_off),
    .i_wdata  (req_wdata),
    .i_rdata  (mem_rdata),
    .o_wmask  (w_wmask),
    .o_wdata  (w_wdata),
    .o_rdata  (w_rdata)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      r_we      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      en_mem    <= 1'b0;
      mem_addr  <= '0;
      mem_rstrb <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_f3      <= req_funct3;
          r_off     <= req_addr[1:0];
          r_we      <= req_we;
          rsp_rdata <= '0;
          rsp_err   <= w_err;
          rsp_valid <= w_err;
          en_mem    <= !w_err;
          mem_rstrb <= !w_err && !req_we;
          mem_wmask <= (!w_err && req_we) ? w_wmask : 4'b0000;
          mem_addr  <= {2'b00, req_addr[31:2]};
          mem_wdata <= w_wdata;
          r_state   <= w_err ? RESP : ACCESS;
        end
        ACCESS: begin
          en_mem    <= 1'b0;
          mem_rstrb <= 1'b0;
          mem_wmask <= 4'b0000;
          rsp_valid <= r_we;
          r_state   <= r_we ? RESP : CAPTURE;
        end
        CAPTURE: begin
          rsp_rdata <= w_rdata;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: scoreboard bench with a behavioural word memory behind the bridge
module tb_lsu_mem_bridge;
  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          acc;
    int          lat;
  } rsp_t;
  typedef struct {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic        r;
  } acc_t;
  logic        clk = 0;
  logic        rst = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        rsp_valid;
  logic        rsp_ready = 1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        en_mem;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 0;
  logic [31:0] mem [0:4095];
  rsp_t        rq[$];
  acc_t        aq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        seen = 0;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif
  lsu_mem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .en_mem     (en_mem),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (en_mem) begin
    for (int i = 0; i < 4; i++) if (mem_wmask[i]) mem[mem_addr[11:0]][8*i+:8] <= mem_wdata[8*i+:8];
    mem_rdata <= mem[mem_addr[11:0]];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (en_mem) begin
      if (aq.size() == 0) chk("unexpected_en_mem", 32'(en_mem), 32'd0);
      else begin
        chk("mem_addr", mem_addr, aq[0].a);
        chk("mem_wmask", 32'(mem_wmask), 32'(aq[0].m));
        chk("mem_rstrb", 32'(mem_rstrb), 32'(aq[0].r));
        if (!aq[0].r) chk("mem_wdata", mem_wdata, aq[0].d);
        void'(aq.pop_front());
      end
    end
    if (rsp_valid) begin
      if (rq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        if (!seen) chk("rsp_latency", 32'(cyc - rq[0].acc), 32'(rq[0].lat));
        seen = 1;
        chk("rsp_err", 32'(rsp_err), 32'(rq[0].err));
        chk("rsp_rdata", rsp_rdata, rq[0].rd);
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (rsp_ready) begin
          void'(rq.pop_front());
          seen = 0;
        end
      end
    end
  end
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic err, input logic [31:0] rd, input logic [3:0] mk, input logic [31:0] mwd,
                     input int hold);
    int n = 0;
    rsp_t r;
    acc_t m;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 0;
      return;
    end
    rsp_ready = (hold == 0);
    r.err = err; r.rd = rd; r.acc = cyc + 1; r.lat = err ? 0 : (we ? 1 : 2);
    rq.push_back(r);
    if (!err) begin
      m.a = {2'b00, a[31:2]}; m.m = we ? mk : 4'b0000; m.d = mwd; m.r = !we;
      aq.push_back(m);
    end
    @(posedge clk); #1 req_valid = 0;
    if (hold != 0) begin
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1 n++; end
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1;
    end
  endtask
  task automatic drain;
    int n = 0;
    while ((rq.size() != 0 || aq.size() != 0) && n < 50) begin @(negedge clk); n++; end
    if (rq.size() != 0 || aq.size() != 0) chk("drain_timeout", 32'(rq.size() + aq.size()), 32'd0);
  endtask
  task automatic chk_reset_vals(input string n);
    chk({n, "_en_mem"}, 32'(en_mem), 32'd0);
    chk({n, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({n, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({n, "_mem_rstrb"}, 32'(mem_rstrb), 32'd0);
    chk({n, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({n, "_mem_addr"}, mem_addr, 32'd0);
    chk({n, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({n, "_rsp_rdata"}, rsp_rdata, 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    // we f3 addr wdata | err rdata | mask memwdata | hold
    req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0);
    req(1, 3'b000, 32'h13, 32'h000000A5, 0, 32'h0,        4'b1000, 32'hA5A5A5A5, 0);
    req(0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFA5, 4'b0000, 32'h0,        0);
    req(0, 3'b100, 32'h13, 32'h0,        0, 32'h000000A5, 4'b0000, 32'h0,        0);
    req(1, 3'b001, 32'h16, 32'h00008001, 0, 32'h0,        4'b1100, 32'h80018001, 0);
    req(0, 3'b001, 32'h16, 32'h0,        0, 32'hFFFF8001, 4'b0000, 32'h0,        0);
    req(0, 3'b101, 32'h16, 32'h0,        0, 32'h00008001, 4'b0000, 32'h0,        0);
    req(0, 3'b000, 32'h10, 32'h0,        0, 32'hFFFFFFEF, 4'b0000, 32'h0,        0);
    req(0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFFA5AD, 4'b0000, 32'h0,        0);
    req(0, 3'b010, 32'h4000, 32'h0,      1, 32'h0,        4'b0000, 32'h0,        0);
    req(0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
    req(1, 3'b101, 32'h10, 32'h1234,     1, 32'h0,        4'b0000, 32'h0,        0);
    req(0, 3'b010, 32'h11, 32'h0,        MIS, MIS ? 32'h0 : 32'hA5ADBEEF, 4'b0000, 32'h0, 0);
    req(1, 3'b010, 32'h3FFC, 32'h11223344, 0, 32'h0,      4'b1111, 32'h11223344, 0);
    req(0, 3'b010, 32'h3FFC, 32'h0,      0, 32'h11223344, 4'b0000, 32'h0,        0);
    req(1, 3'b010, 32'h18, 32'hCAFEF00D, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 0);
    drain();
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h12345678;
    @(posedge clk); #1 req_valid = 0;
    chk("pre_reset_en_mem", 32'(en_mem), 32'd1);
    rst = 1;
    #1 chk_reset_vals("midop");
    chk("midop_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst = 0;
    req(0, 3'b010, 32'h18, 32'h0,        0, 32'hCAFEF00D, 4'b0000, 32'h0,        0);
    req(0, 3'b010, 32'h10, 32'h0,        0, 32'hA5ADBEEF, 4'b0000, 32'h0,        5);
    drain();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
